// File: rtl/tx_sched_pkg.sv
// rtl/tx_sched_pkg.sv - shared state encoding and default timing constants for the tx frame scheduler
package tx_sched_pkg;

    // Encoding 2'd3 is deliberately unused; the FSM treats it as illegal and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_GAP_TICKS     = 64;
    localparam int DEF_TIMEOUT_TICKS = 8192;
    localparam int DEF_CNT_W         = 16;
    localparam int TICK_W            = 16;

endpackage

// File: rtl/ce_tick_counter.sv
// rtl/ce_tick_counter.sv - 16-bit clock-enable tick counter with sync clear and terminal-count flag
module ce_tick_counter
    import tx_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ce,
    input  logic [TICK_W-1:0] terminal,
    output logic              at_terminal
);

    logic [TICK_W-1:0] count;

    // Count qualified ticks; clear has priority so a state entry always starts from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (ce) begin
            count <= count + 16'd1;
        end
    end

    // Flag the tick on which the counter already holds the terminal value
    assign at_terminal = ce && (count == terminal);

endmodule

// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - packet start sequencer with config latch, inter-packet gap and send timeout
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int GAP_TICKS     = DEF_GAP_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk_32M768,
    input  logic             rst_n_32M768,
    input  logic             clk_1M024,
    input  logic             tx_en,
    input  logic             err_clr,
    input  logic [3:0]       MODE_CTRL_req,
    input  logic [3:0]       DELAY_CNT_req,
    input  logic [15:0]      TX_PHASE_CONFIG_req,
    input  logic             pkt_sent,
    output logic [3:0]       MODE_CTRL,
    output logic [3:0]       DELAY_CNT,
    output logic [15:0]      TX_PHASE_CONFIG,
    output logic             pkt_start,
    output logic             chain_run,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_count,
    output logic             timeout_err,
    output logic [1:0]       state_o
);

    localparam logic [TICK_W-1:0] GAP_TC     = TICK_W'(GAP_TICKS - 1);
    localparam logic [TICK_W-1:0] TIMEOUT_TC = TICK_W'(TIMEOUT_TICKS - 1);

    state_t state;
    state_t state_next;
    logic   start_evt;
    logic   sent_evt;
    logic   tmo_evt;
    logic   cnt_clr;
    logic   gap_tc;
    logic   tmo_tc;

    // Both tick counters restart whenever the FSM enters a state, including GAP->SEND
    assign cnt_clr = (state_next != state);

    ce_tick_counter u_gap_cnt (
        .clk         (clk_32M768),
        .rst_n       (rst_n_32M768),
        .clr         (cnt_clr),
        .ce          (clk_1M024 && (state == ST_GAP)),
        .terminal    (GAP_TC),
        .at_terminal (gap_tc)
    );

    ce_tick_counter u_tmo_cnt (
        .clk         (clk_32M768),
        .rst_n       (rst_n_32M768),
        .clr         (cnt_clr),
        .ce          (clk_1M024 && (state == ST_SEND)),
        .terminal    (TIMEOUT_TC),
        .at_terminal (tmo_tc)
    );

    // State register
    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and one-cycle event strobes; pkt_sent outranks the timeout tick
    always_comb begin
        state_next = state;
        start_evt  = 1'b0;
        sent_evt   = 1'b0;
        tmo_evt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clk_1M024 && tx_en) begin
                    state_next = ST_SEND;
                    start_evt  = 1'b1;
                end
            end
            ST_SEND: begin
                if (pkt_sent) begin
                    state_next = ST_GAP;
                    sent_evt   = 1'b1;
                end else if (tmo_tc) begin
                    state_next = ST_GAP;
                    tmo_evt    = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_tc) begin
                    if (tx_en) begin
                        state_next = ST_SEND;
                        start_evt  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs: config latched only at packet start, status derived from the next state
    always_ff @(posedge clk_32M768 or negedge rst_n_32M768) begin
        if (!rst_n_32M768) begin
            MODE_CTRL       <= '0;
            DELAY_CNT       <= '0;
            TX_PHASE_CONFIG <= '0;
            pkt_start       <= 1'b0;
            chain_run       <= 1'b0;
            busy            <= 1'b0;
            pkt_count       <= '0;
            timeout_err     <= 1'b0;
        end else begin
            pkt_start <= start_evt;
            chain_run <= (state_next == ST_SEND);
            busy      <= (state_next != ST_IDLE);
            if (start_evt) begin
                MODE_CTRL       <= MODE_CTRL_req;
                DELAY_CNT       <= DELAY_CNT_req;
                TX_PHASE_CONFIG <= TX_PHASE_CONFIG_req;
            end
            if (sent_evt) begin
                pkt_count <= pkt_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (tmo_evt) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign state_o = state;

endmodule
